// File: rtl/tx_ep_arbiter_pkg.sv
// Shared definitions for the endpoint TX arbiter: FSM state encodings and the
// TLP fmt/type codes used by the TX clients that sit behind this arbiter.
package tx_ep_arbiter_pkg;

    // One-hot arbiter states
    typedef enum logic [3:0] {
        S_ARB   = 4'b0001,  // s0: waiting for a request
        S_GRANT = 4'b0010,  // s1: my_turn asserted, waiting for the client to drive
        S_OWNED = 4'b0100,  // s2: client owns TRN TX / cfg_interrupt
        S_GAP   = 4'b1000   // s3: idle gap before the next arbitration
    } state_e;

    // TLP header fmt field
    localparam logic [1:0] TLP_FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] TLP_FMT_4DW_NODATA = 2'b01;
    localparam logic [1:0] TLP_FMT_3DW_DATA   = 2'b10;
    localparam logic [1:0] TLP_FMT_4DW_DATA   = 2'b11;

    // TLP header type field
    localparam logic [4:0] TLP_TYPE_MEM = 5'b00000;
    localparam logic [4:0] TLP_TYPE_CPL = 5'b01010;
    localparam logic [4:0] TLP_TYPE_MSG = 5'b10000;

endpackage

// File: rtl/tx_ep_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  i_req   : per-client request vector
//  i_last  : index of the previous grantee
//  o_idx   : first requesting client searching upward from i_last+1 (mod NUM_REQ)
//  o_valid : any request present
module tx_ep_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);
    // w_cand[k] is the client at distance k+1 from i_last, wrapped mod NUM_REQ.
    // One subtraction suffices since i_last+k+1 <= 2*NUM_REQ-1.
    logic [IDX_W-1:0] w_cand [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        logic [IDX_W:0] w_sum;
        assign w_sum     = {1'b0, i_last} + (IDX_W+1)'(k + 1);
        assign w_cand[k] = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                           IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
    end

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) o_idx = w_cand[k];
        end
    end
endmodule

// File: rtl/tx_ep_arbiter.sv
// Round-robin arbiter for the PCIe endpoint TRN TX interface and cfg_interrupt.
//  i_trn_clk           : endpoint user clock
//  i_reset             : synchronous, active-high
//  i_req_ep            : per-client request (level)
//  i_driving_interface : per-client "I own the interface" (level)
//  o_my_turn           : one-hot grant, registered
//  o_owner_idx         : index of current/last grantee
//  o_busy              : high in GRANT, OWNED or GAP
//  o_proto_err         : sticky, drive by a non-owner or while arbitrating
//  o_hold_err          : sticky, owner held the interface for MAX_HOLD cycles
module tx_ep_arbiter
    import tx_ep_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 4096,
    parameter int GAP_CYC  = 1
) (
    input  logic               i_trn_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req_ep,
    input  logic [NUM_REQ-1:0] i_driving_interface,
    output logic [NUM_REQ-1:0] o_my_turn,
    output logic [IDX_W-1:0]   o_owner_idx,
    output logic               o_busy,
    output logic               o_proto_err,
    output logic               o_hold_err
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    state_e             r_state;
    logic [NUM_REQ-1:0] r_my_turn;
    logic [IDX_W-1:0]   r_owner;
    logic               r_busy;
    logic               r_proto_err;
    logic               r_hold_err;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;
    logic [NUM_REQ-1:0] w_owner_mask;
    logic               w_own_drv;
    logic               w_own_req;
    logic               w_proto_hit;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // Searching from the last grantee gives it lowest priority next round.
    tx_ep_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (i_req_ep),
        .i_last  (r_owner),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    assign w_owner_mask = NUM_REQ'(1) << r_owner;
    assign w_own_drv    = i_driving_interface[r_owner];
    assign w_own_req    = i_req_ep[r_owner];
    assign w_proto_hit  = (|(i_driving_interface & ~w_owner_mask)) ||
                          ((r_state == S_ARB) && (|i_driving_interface));
    assign w_cnt_nxt    = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;

    always_ff @(posedge i_trn_clk) begin
        if (i_reset) begin
            r_state     <= S_ARB;
            r_my_turn   <= '0;
            r_owner     <= IDX_W'(NUM_REQ - 1);  // client 0 wins first
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
            r_hold_err  <= 1'b0;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (w_proto_hit) r_proto_err <= 1'b1;
            case (r_state)
                S_ARB: begin
                    if (w_pick_vld) begin
                        r_owner   <= w_pick_idx;
                        r_my_turn <= NUM_REQ'(1) << w_pick_idx;
                        r_busy    <= 1'b1;
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Driving wins over a same-cycle request drop.
                    if (w_own_drv) begin
                        r_my_turn  <= '0;
                        r_hold_cnt <= '0;
                        r_state    <= S_OWNED;
                    end else if (!w_own_req) begin
                        r_my_turn <= '0;
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= S_GAP;
                    end
                end
                S_OWNED: begin
                    if (!w_own_drv) begin
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= S_GAP;
                    end else begin
                        // Watchdog only flags; the owner keeps the interface.
                        r_hold_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == CNT_MAX) r_hold_err <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_ARB;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_my_turn <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= S_ARB;
                end
            endcase
        end
    end

    assign o_my_turn   = r_my_turn;
    assign o_owner_idx = r_owner;
    assign o_busy      = r_busy;
    assign o_proto_err = r_proto_err;
    assign o_hold_err  = r_hold_err;
endmodule
